// File: rtl/clock_enable_ctrl_if.sv
// Control/status bundle between the run/step/halt scheduler and whatever drives it.
// Every control is a level signal that the scheduler samples on each mclk edge.
interface clock_enable_ctrl_if #(
  parameter int DIV_W = 27
);
  logic             mode_run;
  logic [DIV_W-1:0] div_sel;
  logic             step_btn;
  logic             hlt;
  logic             resume;
  logic             mclk_en;
  logic             halted;
  logic [1:0]       state_dbg;

  modport master (
    output mode_run, div_sel, step_btn, hlt, resume,
    input  mclk_en, halted, state_dbg
  );

  modport slave (
    input  mode_run, div_sel, step_btn, hlt, resume,
    output mclk_en, halted, state_dbg
  );
endinterface

// File: rtl/clock_enable_ctrl.sv
// Run/step/halt scheduler for the global mclk_en: divided free-run pulses, debounced
// single-step pulses, and a HALT state entered on the cycle that executes HLT.
module clock_enable_ctrl #(
  parameter int DIV_W           = 27,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DEB_W           = 20
) (
  input logic              mclk,
  input logic              rst_n,
  clock_enable_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_STEP = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             en_q, en_d;
  logic             halted_q, halted_d;

  logic             sync0_q, sync1_q;
  logic             deb_lvl_q;
  logic [DEB_W-1:0] deb_cnt_q;
  logic             deb_flip;
  logic             step_evt;

  // The debounced level flips on the DEBOUNCE_CYCLES-th consecutive disagreeing sample.
  assign deb_flip = (sync1_q != deb_lvl_q) && (deb_cnt_q == DEB_LAST);
  assign step_evt = deb_flip && sync1_q;

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      sync0_q   <= 1'b0;
      sync1_q   <= 1'b0;
      deb_lvl_q <= 1'b0;
      deb_cnt_q <= '0;
    end else begin
      sync0_q <= bus.step_btn;
      sync1_q <= sync0_q;
      if (sync1_q == deb_lvl_q) begin
        deb_cnt_q <= '0;
      end else if (deb_flip) begin
        deb_lvl_q <= sync1_q;
        deb_cnt_q <= '0;
      end else begin
        deb_cnt_q <= deb_cnt_q + DEB_W'(1);
      end
    end
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_STEP;
      cnt_q    <= '0;
      en_q     <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      en_q     <= en_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    en_d     = 1'b0;
    halted_d = halted_q;
    // HLT executes on an enabled edge and outranks any concurrent mode change.
    if (bus.hlt && en_q) begin
      state_d  = ST_HALT;
      cnt_d    = '0;
      halted_d = 1'b1;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (!bus.mode_run) begin
            state_d = ST_STEP;
            cnt_d   = '0;
          end else if (cnt_q >= bus.div_sel) begin
            cnt_d = '0;
            en_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + DIV_W'(1);
          end
        end
        ST_STEP: begin
          cnt_d = '0;
          if (bus.mode_run) begin
            state_d = ST_RUN;
          end else begin
            en_d = step_evt;
          end
        end
        ST_HALT: begin
          if (bus.resume) begin
            state_d  = bus.mode_run ? ST_RUN : ST_STEP;
            cnt_d    = '0;
            halted_d = 1'b0;
          end
        end
        default: begin
          state_d  = ST_STEP;
          cnt_d    = '0;
          halted_d = 1'b0;
        end
      endcase
    end
  end

  assign bus.mclk_en   = en_q;
  assign bus.halted    = halted_q;
  assign bus.state_dbg = state_q;

endmodule
